// File: rtl/global_pkg.sv
// Shared bus types: operations, access sizes, address map entries, bus FSM states.
// No logic; types, the default four-device map and an alignment helper only.
// Imported by the bus decoder and its lane-steering sub-module.
package global_pkg;

  typedef enum logic [1:0] {
    MEM_NONE   = 2'd0,
    LOAD_DATA  = 2'd1,
    FETCH_DATA = 2'd2,
    STORE_DATA = 2'd3
  } memory_operation_t;

  typedef enum logic [1:0] {
    BYTE      = 2'd0,
    HALF_WORD = 2'd1,
    WORD      = 2'd2
  } access_size_t;

  // Inclusive byte-address window owned by one device.
  typedef struct packed {
    logic [31:0] base;
    logic [31:0] limit;
  } memory_map_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } bus_state_t;

  localparam memory_map_t DEFAULT_MAP [4] = '{
    '{base: 32'h0000_0000, limit: 32'h0000_FFFF},
    '{base: 32'h1000_0000, limit: 32'h1000_00FF},
    '{base: 32'h2000_0000, limit: 32'h2000_0FFF},
    '{base: 32'h8000_0000, limit: 32'h8FFF_FFFF}
  };

  // Halfwords must sit on even addresses, words on 4-byte boundaries.
  function automatic logic misaligned(access_size_t size, logic [1:0] addr_lo);
    case (size)
      HALF_WORD: misaligned = addr_lo[0];
      WORD:      misaligned = (addr_lo != 2'b00);
      default:   misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/byte_lane_steer.sv
// Byte-lane steering: store-side lane enables and data replication, load-side alignment.
// Purely combinational, zero latency.
// No handshake of its own; the decoder chooses which address/size drive it.
module byte_lane_steer
  import global_pkg::*;
(
  input  access_size_t size,
  input  logic [1:0]   addr_lo,
  input  logic [31:0]  wdata,
  input  logic [31:0]  raw_rdata,
  output logic [3:0]   sel,
  output logic [31:0]  lane_wdata,
  output logic [31:0]  rdata
);

  logic [31:0] shifted;

  // Lane enables and replicated store data so any lane a device samples is correct.
  always_comb begin
    sel        = 4'b1111;
    lane_wdata = wdata;
    case (size)
      BYTE: begin
        sel        = 4'b0001 << addr_lo;
        lane_wdata = {4{wdata[7:0]}};
      end
      HALF_WORD: begin
        sel        = addr_lo[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{wdata[15:0]}};
      end
      default: begin
        sel        = 4'b1111;
        lane_wdata = wdata;
      end
    endcase
  end

  // Move the addressed lanes down to bit 0 and zero-extend to the access size.
  always_comb begin
    shifted = raw_rdata >> {addr_lo, 3'b000};
    case (size)
      BYTE:      rdata = {24'h0, shifted[7:0]};
      HALF_WORD: rdata = {16'h0, shifted[15:0]};
      default:   rdata = shifted;
    endcase
  end

endmodule

// File: rtl/bus_decoder.sv
// Single-master to N-device bus decoder with alignment checks and a BUSY watchdog.
// Latency: 3 cycles req->ack for a zero-wait device, 2 cycles for decode/alignment errors.
// Master holds the request until the one-cycle ack; devices stall by withholding dev_ack.
module bus_decoder
  import global_pkg::*;
#(
  parameter int          N_DEV          = 4,
  parameter memory_map_t MAP [N_DEV]    = DEFAULT_MAP,
  parameter int          TIMEOUT        = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  memory_operation_t     op,
  input  logic [31:0]           addr,
  input  access_size_t          size,
  input  logic [31:0]           wdata,
  output logic                  ack,
  output logic                  err,
  output logic [31:0]           rdata,
  output logic [N_DEV-1:0]      dev_cyc,
  output logic                  dev_we,
  output logic [31:0]           dev_addr,
  output logic [3:0]            dev_sel,
  output logic [31:0]           dev_wdata,
  input  logic [N_DEV-1:0]      dev_ack,
  input  logic [32*N_DEV-1:0]   dev_rdata
);

  localparam int IDX_W = (N_DEV > 1) ? $clog2(N_DEV) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  bus_state_t         state, state_nx;
  logic [IDX_W-1:0]   idx_q, hit_idx;
  logic               hit;
  logic [N_DEV-1:0]   hit_onehot;
  logic [CNT_W-1:0]   cnt;
  access_size_t       size_q, st_size;
  logic [1:0]         lo_q, st_lo;
  logic [31:0]        err_rdata_unused;
  logic [31:0]        raw_rdata, st_sel_wdata, st_rdata;
  logic [3:0]         st_sel;
  logic               start, reject, sel_ack, tmo;

  assign err_rdata_unused = 32'h0;

  // Address decode; scanning downwards lets the lowest matching index win.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    hit_onehot = '0;
    for (int i = N_DEV - 1; i >= 0; i--) begin
      if (addr >= MAP[i].base && addr <= MAP[i].limit) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
    hit_onehot[hit_idx] = hit;
  end

  assign start     = (state == IDLE) && req && (op != MEM_NONE);
  assign reject    = !hit || misaligned(size, addr[1:0]);
  assign sel_ack   = dev_ack[idx_q];
  assign tmo       = (cnt == CNT_W'(TIMEOUT - 1));
  assign raw_rdata = dev_rdata[{idx_q, 5'b00000} +: 32];

  // While idle the live request feeds the steering; afterwards the captured one does,
  // so the load alignment cannot be disturbed by a master that drops req mid-transfer.
  assign st_size = (state == IDLE) ? size : size_q;
  assign st_lo   = (state == IDLE) ? addr[1:0] : lo_q;

  byte_lane_steer u_steer (
    .size       (st_size),
    .addr_lo    (st_lo),
    .wdata      (wdata),
    .raw_rdata  (raw_rdata),
    .sel        (st_sel),
    .lane_wdata (st_sel_wdata),
    .rdata      (st_rdata)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state: errors skip BUSY; an ack outranks a same-cycle timeout.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = reject ? RESP : BUSY;
      BUSY:    if (sel_ack || tmo) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Master completion strobe is simply the RESP state.
  always_comb begin
    ack = (state == RESP);
  end

  // Transfer datapath: capture request at accept, capture response on ack or timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q     <= '0;
      cnt       <= '0;
      size_q    <= BYTE;
      lo_q      <= 2'b00;
      err       <= 1'b0;
      rdata     <= 32'h0;
      dev_cyc   <= '0;
      dev_we    <= 1'b0;
      dev_addr  <= 32'h0;
      dev_sel   <= 4'h0;
      dev_wdata <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt <= '0;
            if (reject) begin
              err   <= 1'b1;
              rdata <= err_rdata_unused;
            end else begin
              err       <= 1'b0;
              idx_q     <= hit_idx;
              size_q    <= size;
              lo_q      <= addr[1:0];
              dev_cyc   <= hit_onehot;
              dev_we    <= (op == STORE_DATA);
              dev_addr  <= {addr[31:2], 2'b00};
              dev_sel   <= st_sel;
              dev_wdata <= st_sel_wdata;
            end
          end
        end
        BUSY: begin
          if (sel_ack) begin
            err     <= 1'b0;
            rdata   <= st_rdata;
            dev_cyc <= '0;
            dev_we  <= 1'b0;
          end else if (tmo) begin
            err     <= 1'b1;
            rdata   <= 32'h0;
            dev_cyc <= '0;
            dev_we  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_decoder.sv
// Directed bench for bus_decoder with default map and timeout.
// Devices answer combinationally when enabled; stray acks can be injected.
// Each transfer reports req->ack cycle count, err, rdata and what the device bus showed.
module tb_bus_decoder;
  import global_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               req;
  memory_operation_t  op;
  logic [31:0]        addr;
  access_size_t       size;
  logic [31:0]        wdata;
  logic               ack, err;
  logic [31:0]        rdata;
  logic [3:0]         dev_cyc;
  logic               dev_we;
  logic [31:0]        dev_addr;
  logic [3:0]         dev_sel;
  logic [31:0]        dev_wdata;
  logic [3:0]         dev_ack;
  logic [127:0]       dev_rdata;

  logic [3:0]         ack_en, stray;
  assign dev_ack = (dev_cyc & ack_en) | stray;

  always #5 clk = ~clk;

  bus_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .op        (op),
    .addr      (addr),
    .size      (size),
    .wdata     (wdata),
    .ack       (ack),
    .err       (err),
    .rdata     (rdata),
    .dev_cyc   (dev_cyc),
    .dev_we    (dev_we),
    .dev_addr  (dev_addr),
    .dev_sel   (dev_sel),
    .dev_wdata (dev_wdata),
    .dev_ack   (dev_ack),
    .dev_rdata (dev_rdata)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Device-side observation during a transfer.
  logic [3:0]  seen_cyc, seen_sel;
  logic [31:0] seen_wd, seen_addr;
  logic        seen_we;
  int          busy_cnt;

  always @(negedge clk) begin
    if (dev_cyc != 4'b0000) begin
      seen_cyc  = seen_cyc | dev_cyc;
      seen_sel  = dev_sel;
      seen_wd   = dev_wdata;
      seen_addr = dev_addr;
      seen_we   = dev_we;
      busy_cnt++;
    end
  end

  int          t_cyc;
  logic        t_err;
  logic [31:0] t_rd;

  // Cycle 1 is the cycle in which req is first presented.
  task automatic run_txn(input memory_operation_t o, input logic [31:0] a,
                         input access_size_t s, input logic [31:0] wd);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    req = 1'b1; op = o; addr = a; size = s; wdata = wd;
    seen_cyc = '0; seen_sel = '0; seen_wd = '0; seen_addr = '0; seen_we = 1'b0;
    busy_cnt = 0; t_cyc = 0; t_err = 1'b0; t_rd = '0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (ack) begin
        t_cyc = i; t_err = err; t_rd = rdata; got = 1'b1;
        break;
      end
    end
    if (!got) check_eq("ack_wait_expired", 32'd0, 32'd1);
    @(posedge clk); #1;
    req = 1'b0; op = MEM_NONE;
  endtask

  int ack_seen;

  initial begin
    rst = 1'b1; req = 1'b0; op = MEM_NONE; addr = '0; size = WORD; wdata = '0;
    ack_en = 4'b1111; stray = 4'b0000;
    dev_rdata = {32'hCAFE_F00D, 32'h1122_3344, 32'hDEAD_BEEF, 32'h0000_0000};
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_ack",     {31'h0, ack},    32'h0);
    check_eq("rst_err",     {31'h0, err},    32'h0);
    check_eq("rst_rdata",   rdata,           32'h0);
    check_eq("rst_dev_cyc", {28'h0, dev_cyc}, 32'h0);
    check_eq("rst_dev_we",  {31'h0, dev_we}, 32'h0);

    // Word load from device 1, zero-wait.
    run_txn(LOAD_DATA, 32'h1000_0004, WORD, 32'h0);
    check_eq("lw_cycles", t_cyc, 32'd3);
    check_eq("lw_err",    {31'h0, t_err}, 32'h0);
    check_eq("lw_rdata",  t_rd, 32'hDEAD_BEEF);
    check_eq("lw_cyc",    {28'h0, seen_cyc}, 32'h2);
    check_eq("lw_addr",   seen_addr, 32'h1000_0004);
    check_eq("lw_sel",    {28'h0, seen_sel}, 32'hF);
    check_eq("lw_we",     {31'h0, seen_we}, 32'h0);

    // Byte store into top lane of device 0.
    run_txn(STORE_DATA, 32'h0000_0003, BYTE, 32'h0000_0055);
    check_eq("sb_cycles", t_cyc, 32'd3);
    check_eq("sb_cyc",    {28'h0, seen_cyc}, 32'h1);
    check_eq("sb_sel",    {28'h0, seen_sel}, 32'h8);
    check_eq("sb_wdata",  seen_wd, 32'h5555_5555);
    check_eq("sb_we",     {31'h0, seen_we}, 32'h1);
    check_eq("sb_addr",   seen_addr, 32'h0000_0000);

    // Halfword store, upper half.
    run_txn(STORE_DATA, 32'h0000_0002, HALF_WORD, 32'hABCD_1234);
    check_eq("sh_sel",   {28'h0, seen_sel}, 32'hC);
    check_eq("sh_wdata", seen_wd, 32'h1234_1234);

    // Byte load from lane 2 of device 2.
    run_txn(LOAD_DATA, 32'h2000_0006, BYTE, 32'h0);
    check_eq("lb_rdata", t_rd, 32'h0000_0022);
    check_eq("lb_sel",   {28'h0, seen_sel}, 32'h4);

    // Fetch behaves as a load; upper halfword of device 3.
    run_txn(FETCH_DATA, 32'h8000_0002, HALF_WORD, 32'h0);
    check_eq("fh_rdata", t_rd, 32'h0000_CAFE);
    check_eq("fh_we",    {31'h0, seen_we}, 32'h0);
    check_eq("fh_cyc",   {28'h0, seen_cyc}, 32'h8);

    // Misaligned halfword: error, no device strobe.
    run_txn(LOAD_DATA, 32'h2000_0001, HALF_WORD, 32'h0);
    check_eq("mis_err",    {31'h0, t_err}, 32'h1);
    check_eq("mis_cycles", t_cyc, 32'd2);
    check_eq("mis_cyc",    {28'h0, seen_cyc}, 32'h0);

    // Unmapped address.
    run_txn(LOAD_DATA, 32'h5000_0000, WORD, 32'h0);
    check_eq("miss_err",    {31'h0, t_err}, 32'h1);
    check_eq("miss_cycles", t_cyc, 32'd2);
    check_eq("miss_cyc",    {28'h0, seen_cyc}, 32'h0);

    // Device 1 stalls 4 cycles while device 0 raises a stray ack.
    dev_rdata[63:32] = 32'h0BAD_F00D;
    ack_en = 4'b0000; stray = 4'b0001;
    fork
      run_txn(LOAD_DATA, 32'h1000_0010, WORD, 32'h0);
      begin
        repeat (6) @(posedge clk);
        #1 ack_en = 4'b0010; stray = 4'b0000;
      end
    join
    ack_en = 4'b1111;
    check_eq("stray_cycles", t_cyc, 32'd7);
    check_eq("stray_busy",   busy_cnt, 32'd5);
    check_eq("stray_rdata",  t_rd, 32'h0BAD_F00D);
    check_eq("stray_err",    {31'h0, t_err}, 32'h0);

    // Device 3 never answers: watchdog.
    ack_en = 4'b0111;
    run_txn(LOAD_DATA, 32'h8000_0000, WORD, 32'h0);
    check_eq("tmo_busy",   busy_cnt, 32'd255);
    check_eq("tmo_cycles", t_cyc, 32'd257);
    check_eq("tmo_err",    {31'h0, t_err}, 32'h1);
    check_eq("tmo_rdata",  t_rd, 32'h0);

    // Reset during the second BUSY cycle of a stalled transfer.
    dev_rdata[63:32] = 32'hDEAD_BEEF;
    ack_en = 4'b0000;
    @(posedge clk); #1;
    req = 1'b1; op = STORE_DATA; addr = 32'h1000_0000; size = WORD; wdata = 32'h1234_5678;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("rb_busy_cyc", {28'h0, dev_cyc}, 32'h2);
    @(posedge clk); #1;
    rst = 1'b1; req = 1'b0; op = MEM_NONE;
    @(posedge clk); #1;
    rst = 1'b0; ack_en = 4'b1111;
    @(negedge clk);
    check_eq("rb_ack",     {31'h0, ack},     32'h0);
    check_eq("rb_err",     {31'h0, err},     32'h0);
    check_eq("rb_rdata",   rdata,            32'h0);
    check_eq("rb_dev_cyc", {28'h0, dev_cyc}, 32'h0);
    check_eq("rb_dev_we",  {31'h0, dev_we},  32'h0);
    check_eq("rb_dev_sel", {28'h0, dev_sel}, 32'h0);
    ack_seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ack) ack_seen++;
    end
    check_eq("rb_no_ack", ack_seen, 32'd0);
    run_txn(LOAD_DATA, 32'h1000_0004, WORD, 32'h0);
    check_eq("rb_after_cycles", t_cyc, 32'd3);
    check_eq("rb_after_rdata",  t_rd, 32'hDEAD_BEEF);
    check_eq("rb_after_err",    {31'h0, t_err}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_decoder.md
BUS_DECODER -- requirements
Module: bus_decoder

Interface
REQ-001 The block SHALL have parameter N_DEV, default 4, giving the number of device ports (range 1..16).
REQ-002 The block SHALL have parameter MAP, an N_DEV-entry array of memory_map_t, default {0x0000_0000..0x0000_FFFF, 0x1000_0000..0x1000_00FF, 0x2000_0000..0x2000_0FFF, 0x8000_0000..0x8FFF_FFFF}; entry i is the inclusive address range of device i.
REQ-003 The block SHALL have parameter TIMEOUT, default 255, giving the maximum number of BUSY cycles before an error is returned.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req  in  1  master request; master holds req, addr, op, size and wdata stable until ack.
REQ-007 op  in  memory_operation_t  LOAD_DATA, FETCH_DATA, STORE_DATA or MEM_NONE.
REQ-008 addr  in  32  byte address.
REQ-009 size  in  access_size_t  BYTE, HALF_WORD or WORD.
REQ-010 wdata  in  32  store data, right-aligned.
REQ-011 ack  out  1  one-cycle completion pulse.
REQ-012 err  out  1  valid with ack; marks a failed transfer.
REQ-013 rdata  out  32  load data, shifted to bit 0 and zero-extended; valid with ack.
REQ-014 dev_cyc  out  N_DEV  one-hot device strobe.
REQ-015 dev_we  out  1  write enable.
REQ-016 dev_addr  out  32  word address with bits [1:0] forced to 0.
REQ-017 dev_sel  out  4  byte-lane enables.
REQ-018 dev_wdata  out  32  lane-replicated store data.
REQ-019 dev_ack  in  N_DEV  per-device completion.
REQ-020 dev_rdata  in  32*N_DEV  device i read data on bits [32i+31:32i].

Function
REQ-021 The FSM SHALL have the states IDLE, BUSY and RESP.
REQ-022 In IDLE, when req=1 and op!=MEM_NONE, the block SHALL decode addr against all entries, with lowest index winning on overlap.
REQ-023 A misaligned access (HALF_WORD with addr[0]=1, or WORD with addr[1:0]!=0) or a decode miss SHALL move to RESP with err=1 and SHALL NOT assert any dev_cyc.
REQ-024 Otherwise the block SHALL register the device index, drive dev_cyc one-hot from the next cycle, and move to BUSY.
REQ-025 dev_sel SHALL be: BYTE 1<<addr[1:0]; HALF_WORD 4'b0011 or 4'b1100 according to addr[1]; WORD 4'b1111.
REQ-026 dev_wdata SHALL be wdata[7:0] replicated four times for BYTE, wdata[15:0] replicated twice for HALF_WORD, and wdata for WORD.
REQ-027 dev_we SHALL be 1 only for STORE_DATA; FETCH_DATA SHALL behave as LOAD_DATA.
REQ-028 In BUSY, dev_ack of the selected device SHALL latch rdata, clear dev_cyc and move to RESP with err=0.
REQ-029 dev_ack from unselected devices SHALL be ignored.
REQ-030 The BUSY cycle counter SHALL reach TIMEOUT only if the selected device does not ack; it SHALL then clear dev_cyc and move to RESP with err=1 and rdata=0.
REQ-031 An ack and a timeout in the same cycle SHALL resolve as ack.
REQ-032 In RESP, ack SHALL be 1 for exactly one cycle, and the block SHALL then return to IDLE.
REQ-033 A new request SHALL be accepted no earlier than the cycle after RESP.
REQ-034 Minimum latency SHALL be 3 cycles from req to ack for a zero-wait device.
REQ-035 Deassertion of req during BUSY SHALL NOT abort the transfer.

Reset
REQ-036 rst SHALL force IDLE on the next edge and clear the counter, and SHALL force ack=0, err=0, rdata=0, dev_cyc=0 and dev_we=0, including mid-transfer.
REQ-037 After rst, the block SHALL NOT emit ack for the aborted transfer.

Structure
REQ-038 memory_map_t, memory_operation_t and access_size_t SHALL come from global_pkg.
REQ-039 A new bus_state_t enum (IDLE, BUSY, RESP) SHALL be added to global_pkg.
REQ-040 Lane steering (sel, wdata and rdata alignment) SHALL be one sub-module, byte_lane_steer.

Verification
REQ-041 The bench SHALL cover: LOAD WORD at 0x1000_0004, device 1 acks on its first BUSY cycle, dev_rdata1=0xDEADBEEF -> ack at cycle 3, err=0, rdata=0xDEADBEEF.
REQ-042 The bench SHALL cover: STORE BYTE at 0x0000_0003 with wdata=0x55 -> dev_cyc=0001, dev_sel=1000, dev_wdata=0x55555555, dev_we=1.
REQ-043 The bench SHALL cover: LOAD HALF_WORD at 0x2000_0001 -> ack with err=1, dev_cyc never asserted.
REQ-044 The bench SHALL cover: LOAD at unmapped 0x5000_0000 -> ack with err=1 at cycle 2.
REQ-045 The bench SHALL cover: device 3 never acks -> dev_cyc drops after 255 BUSY cycles, ack with err=1, rdata=0.
REQ-046 The bench SHALL cover: rst asserted on the 2nd BUSY cycle -> next cycle all outputs are 0, no ack, and a following request completes normally.
